// File: rtl/truth_table_sweeper.sv
// Steps a 3-bit vector through 0..7, waits SETTLE_CYCLES per vector, captures s into truth_table.
// Optional macro SWEEP_MISMATCH_STOP_EN ends the sweep at the first bit that differs from EXPECTED.
// The captured-table port is named truth_table because 'table' is a reserved word in SystemVerilog.
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [7:0]  EXPECTED      = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       s,
   output logic       busy,
   output logic       done,
   output logic [7:0] truth_table,
   output logic       match
);

   // A setting of 0 is treated the same as 1.
   localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam logic [3:0]  CNT_LOAD   = 4'(SETTLE_EFF - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t     state, state_d;
   logic [2:0] idx, idx_d;
   logic [3:0] cnt, cnt_d;
   logic [7:0] table_d, captured;
   logic       busy_d, done_d, match_d, stop;

   // The vector index doubles as the driven vector, so {a,b,c} holds 7 after the sweep.
   assign {a, b, c} = idx;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d  = state;
      idx_d    = idx;
      cnt_d    = cnt;
      table_d  = truth_table;
      match_d  = match;
      busy_d   = busy;
      done_d   = 1'b0;
      captured = truth_table;
      captured[idx] = s;
`ifdef SWEEP_MISMATCH_STOP_EN
      stop = (idx == 3'd7) || (s != EXPECTED[idx]);
`else
      stop = (idx == 3'd7);
`endif
      case (state)
         IDLE: begin
            if (start) begin
               idx_d   = 3'd0;
               table_d = 8'h00;
               match_d = 1'b0;
               cnt_d   = CNT_LOAD;
               busy_d  = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == 4'd0) state_d = SAMPLE;
            else             cnt_d   = cnt - 4'd1;
         end
         SAMPLE: begin
            table_d = captured;
            if (stop) begin
               // An early stop always carries a differing bit, so this compare yields 0 there.
               match_d = (captured == EXPECTED);
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d   = idx + 3'd1;
               cnt_d   = CNT_LOAD;
               state_d = SETTLE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 3'd0;
         cnt         <= 4'd0;
         truth_table <= 8'h00;
         match       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state       <= state_d;
         idx         <= idx_d;
         cnt         <= cnt_d;
         truth_table <= table_d;
         match       <= match_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: launches push expected sweep results, negedge monitors pop them on done.
module tb_truth_table_sweeper;

   typedef struct {
      logic [7:0] tbl;
      logic       m;
      int         done_cyc;
      int         busy_n;
   } exp_t;

`ifdef SWEEP_MISMATCH_STOP_EN
   localparam int DUR01 = 4;
`else
   localparam int DUR01 = 16;
`endif

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, start3 = 1'b0;
   logic       a, b, c, s, busy, done, match;
   logic       a3, b3, c3, busy3, done3, match3;
   logic [7:0] tt, tt3;
   logic [7:0] pattern = 8'hFF;
   logic       s3 = 1'b1;

   exp_t       q1[$], q3[$];
   logic [2:0] vq[$];
   exp_t       e1, e3;
   int         cyc = 0, bc1 = 0, bc3 = 0;
   int         checks = 0, passes = 0;

   truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hFF)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .s(s),
      .busy(busy), .done(done), .truth_table(tt), .match(match));

   truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(8'hFF)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .c(c3), .s(s3),
      .busy(busy3), .done(done3), .truth_table(tt3), .match(match3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Unit under sweep: pattern bit i is the response for vector i.
   always_comb s = pattern[{a, b, c}];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic compare_done(input string tag, input exp_t e, input logic [7:0] t,
                               input logic m, input int bn);
      check({tag, "_table"}, t, e.tbl);
      check({tag, "_match"}, m, e.m);
      check({tag, "_done_cycle"}, cyc, e.done_cyc);
      check({tag, "_busy_cycles"}, bn, e.busy_n);
   endtask

   always @(negedge clk) begin
      if (rst) bc1 = 0;
      else begin
         if (busy) begin
            bc1++;
            if (vq.size() > 0) check("vector", {a, b, c}, vq.pop_front());
         end
         if (done) begin
            if (q1.size() == 0) check("unexpected_done", q1.size(), 1);
            else begin
               e1 = q1.pop_front();
               compare_done("sweep", e1, tt, match, bc1);
            end
            bc1 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) bc3 = 0;
      else begin
         if (busy3) bc3++;
         if (done3) begin
            if (q3.size() == 0) check("unexpected_done3", q3.size(), 1);
            else begin
               e3 = q3.pop_front();
               compare_done("sweep3", e3, tt3, match3, bc3);
            end
            bc3 = 0;
         end
      end
   end

   task automatic launch(input logic [7:0] pat, input bit push, input logic [7:0] et,
                         input logic em, input int dur);
      @(negedge clk);
      pattern = pat;
      start   = 1'b1;
      if (push) q1.push_back('{et, em, cyc + 1 + dur, dur});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (q1.size() == 0) break;
         @(negedge clk);
      end
      check("drain", q1.size(), 0);
   endtask

   task automatic wait_vec(input logic [2:0] v);
      for (int i = 0; i < 60; i++) begin
         if ({a, b, c} == v) break;
         @(negedge clk);
      end
      check("reach_vector", {a, b, c}, v);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_table", tt, 0);
      check("rst_vec", {a, b, c}, 0);
      check("rst_match", match, 0);
      check("rst_busy3", busy3, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full sweep with s tied high, every vector held two cycles.
      for (int v = 0; v < 8; v++) begin
         vq.push_back(3'(v));
         vq.push_back(3'(v));
      end
      launch(8'hFF, 1, 8'hFF, 1'b1, 16);
      drain(40);
      repeat (3) @(negedge clk);
      check("hold_vec7", {a, b, c}, 7);
      check("hold_table", tt, 8'hFF);
      check("hold_match", match, 1);
      check("idle_busy", busy, 0);
      check("vector_queue_empty", vq.size(), 0);

      // s = ~a&~b&~c, and a table that differs only in its last bit.
      launch(8'h01, 1, 8'h01, 1'b0, DUR01);
      drain(40);
      launch(8'h7F, 1, 8'h7F, 1'b0, 16);
      drain(40);

      // Reset during vector 4 aborts without a done pulse.
      launch(8'hFF, 0, 8'h00, 1'b0, 16);
      wait_vec(3'd4);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_table", tt, 0);
      check("abort_vec", {a, b, c}, 0);
      check("abort_match", match, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("post_abort_idle", busy, 0);
      launch(8'hFF, 1, 8'hFF, 1'b1, 16);
      drain(40);

      // A second start during vector 3 is ignored.
      launch(8'hFF, 1, 8'hFF, 1'b1, 16);
      wait_vec(3'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain(40);
      repeat (20) @(negedge clk);

      // SETTLE_CYCLES=3 with start held: back-to-back sweeps.
      @(negedge clk);
      start3 = 1'b1;
      q3.push_back('{8'hFF, 1'b1, cyc + 1 + 32, 32});
      q3.push_back('{8'hFF, 1'b1, cyc + 1 + 66, 32});
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done3) break;
      end
      check("held_first_done", done3, 1);
      @(negedge clk);
      check("held_idle_gap", busy3, 0);
      @(negedge clk);
      check("held_restart_busy", busy3, 1);
      check("held_restart_table", tt3, 0);
      start3 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (q3.size() == 0) break;
         @(negedge clk);
      end
      check("drain3", q3.size(), 0);
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the wait cycles per vector before sampling; legal range 1..15.
REQ-002 Parameter EXPECTED, default 8'hFF, is the reference truth table; bit i is the expected s for {a,b,c}=i.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 a, b, c  output  1 each  drive vector to the downstream combinational unit; a is the MSB and c is the LSB of the vector index.
REQ-007 s  input  1  response of the unit under sweep.
REQ-008 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-009 done  output  1  one-cycle pulse marking the end of a sweep.
REQ-010 table  output  8  captured truth table; bit i holds s sampled for vector i.
REQ-011 match  output  1  high when the captured table equals EXPECTED; valid while done is high and held afterwards.

Function
REQ-012 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE.
REQ-013 IDLE with start=1: idx<=0, {a,b,c}<=3'b000, table<=0, match<=0, settle counter loaded, next state SETTLE, busy<=1.
REQ-014 SETTLE SHALL hold {a,b,c} stable for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-015 SAMPLE SHALL write s into table[idx] at the clock edge leaving SAMPLE.
REQ-016 SAMPLE with idx<7: idx<=idx+1, {a,b,c}<=idx+1, reload counter, go to SETTLE.
REQ-017 SAMPLE with idx==7: go to DONE, busy<=0, match<=({s,table[6:0]}==EXPECTED).
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE; table and match SHALL hold until the next accepted start.
REQ-019 A full sweep SHALL take 8*(SETTLE_CYCLES+1) busy cycles; done is high on the following cycle (cycle 17 after the start edge for SETTLE_CYCLES=1).
REQ-020 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-021 start held high continuously SHALL begin a new sweep on the cycle after DONE.
REQ-022 {a,b,c} SHALL keep vector 7 after the sweep until the next start or reset.
REQ-023 The idx counter SHALL be 3 bits and never wrap during a sweep; termination is decided by idx==7.
REQ-024 A SETTLE_CYCLES value of 0 SHALL behave as 1.

Reset
REQ-025 On rst high, asynchronously: state=IDLE; idx=0; {a,b,c}=000; busy=0; done=0; table=0; match=0.
REQ-026 rst asserted mid-sweep SHALL abort the sweep with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-027 Macro SWEEP_MISMATCH_STOP_EN defined:
  - In SAMPLE, if s != EXPECTED[idx], the captured bit SHALL be written and the FSM SHALL go directly to DONE with match=0.
  - Unsampled table bits SHALL remain 0.
REQ-028 Macro SWEEP_MISMATCH_STOP_EN undefined: all 8 vectors SHALL always be swept, and match is computed only at the end.

Verification
REQ-029 Reset, then start pulse with SETTLE_CYCLES=1 and s tied to 1 -> vectors 000..111 in order, each held 2 cycles; done on cycle 17; table=8'hFF; match=1.
REQ-030 s driven as ~a&~b&~c with EXPECTED=8'hFF -> table=8'h01, match=0 (macro undefined); with macro defined -> done after vector 1, table=8'h01, match=0.
REQ-031 rst asserted during vector 4 -> busy, done, table and {a,b,c} all 0 immediately; no done pulse; a later start yields a clean full sweep.
REQ-032 start pulsed again during vector 3 -> ignored; exactly one done pulse at the original completion cycle.
REQ-033 SETTLE_CYCLES=3 with start held high -> 32 busy cycles, done, then a second sweep begins the next cycle with table cleared to 0.
